// File: rtl/serial_mouse_uart_if.sv
// CPU I/O bus and mouse-packet strobe bundle for serial_mouse_uart.
// The DUT takes the slave side; the CPU/packet source takes the master side.
interface serial_mouse_uart_if;
  logic        iPktValid;
  logic [23:0] iPkt;
  logic [19:0] iAddr;
  logic        iWr;
  logic [7:0]  iWrData;
  logic        iRd;
  logic [7:0]  oRdData;
  logic        oSel;
  logic        oIntr;

  modport master (
    output iPktValid, iPkt, iAddr, iWr, iWrData, iRd,
    input  oRdData, oSel, oIntr
  );

  modport slave (
    input  iPktValid, iPkt, iAddr, iWr, iWrData, iRd,
    output oRdData, oSel, oIntr
  );
endinterface

// File: rtl/serial_mouse_uart.sv
// PS/2 sample -> Microsoft serial-mouse bytes, queued behind an 8250-style COM port.
// Define SERIAL_MOUSE_MBUTTON_EN for the Logitech 3-button (4th byte) extension.
module serial_mouse_uart #(
  parameter logic [19:0] BASE       = 20'h003F8,
  parameter int          FIFO_DEPTH = 16
) (
  input logic          iClk,
  input logic          iRst,
  serial_mouse_uart_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
`ifdef SERIAL_MOUSE_MBUTTON_EN
  localparam logic [PW:0] PKT_SLOTS = (PW+1)'(4);
  localparam logic [PW:0] IDENT_LEN = (PW+1)'(2);
`else
  localparam logic [PW:0] PKT_SLOTS = (PW+1)'(3);
  localparam logic [PW:0] IDENT_LEN = (PW+1)'(1);
`endif

  typedef enum logic [2:0] {
    IDLE, B0, B1, B2
`ifdef SERIAL_MOUSE_MBUTTON_EN
    , B3
`endif
  } tSeqState;

  tSeqState state, stateNext;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [PW:0] count, freeSlots;
  logic [3:0]  ier;
  logic [7:0]  lcr, scr, dll, dlm;
  logic [4:0]  mcr;
  logic        oe, rdPrev, intr;
  logic [7:0]  pktByte0, pktByte1, pktByte2;
  logic [2:0]  off;
  logic        sel, rdAct, rdFirst, wrAct, dlab, dr, dtrRts;
  logic        identHit, pktAccept, pktDrop, push, pop;
  logic [7:0]  pushData, rdData;
  logic [8:0]  x9, y9;
  logic [9:0]  yn;
  logic [7:0]  dx, dy, st;
  logic        unusedBits;

  assign off      = bus.iAddr[2:0];
  assign sel      = (bus.iAddr[19:3] == BASE[19:3]);
  assign rdAct    = bus.iRd & sel;
  assign rdFirst  = rdAct & ~rdPrev;
  assign wrAct    = bus.iWr & sel;
  assign dlab     = lcr[7];
  assign dr       = (count != '0);
  assign dtrRts   = mcr[0] & mcr[1];
  assign freeSlots = (PW+1)'(FIFO_DEPTH) - count;
  assign identHit = wrAct && (off == 3'd4) && bus.iWrData[0] && bus.iWrData[1] && !dtrRts;
  assign pktAccept = bus.iPktValid && dtrRts && (state == IDLE) && (freeSlots >= PKT_SLOTS);
  assign pktDrop  = bus.iPktValid && dtrRts && !pktAccept;
  assign pop      = rdFirst && (off == 3'd0) && !dlab && dr;
  assign st       = bus.iPkt[23:16];
  assign unusedBits = ^bus.iPkt[3:2];

  // Sign-extend into 9 bits, saturate on PS/2 overflow, flip Y (PS/2 up = serial down).
  always_comb begin
    x9 = {st[4], bus.iPkt[15:8]};
    y9 = {st[5], bus.iPkt[7:0]};
    if (st[6]) x9 = st[4] ? 9'h100 : 9'h0FF;
    if (st[7]) y9 = st[5] ? 9'h100 : 9'h0FF;
    yn = -{y9[8], y9};
    if ($signed(x9) > 9'sd127)       dx = 8'h7F;
    else if ($signed(x9) < -9'sd128) dx = 8'h80;
    else                             dx = x9[7:0];
    if ($signed(yn) > 10'sd127)       dy = 8'h7F;
    else if ($signed(yn) < -10'sd128) dy = 8'h80;
    else                              dy = yn[7:0];
  end

`ifdef SERIAL_MOUSE_MBUTTON_EN
  logic       midHeld, has4th;
  logic [7:0] pktByte3;

  always_ff @(posedge iClk) begin
    if (iRst || identHit) midHeld <= 1'b0;
    else if (pktAccept)   midHeld <= st[2];
  end
`endif

  // NOTE: the packet latch and FIFO storage carry no reset; the state/count logic masks stale contents.
  always_ff @(posedge iClk) begin
    if (pktAccept) begin
      pktByte0 <= {2'b01, st[0], st[1], dy[7:6], dx[7:6]};
      pktByte1 <= {2'b00, dx[5:0]};
      pktByte2 <= {2'b00, dy[5:0]};
`ifdef SERIAL_MOUSE_MBUTTON_EN
      has4th   <= st[2] | midHeld;
      pktByte3 <= st[2] ? 8'h20 : 8'h00;
`endif
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) state <= IDLE;
    else      state <= stateNext;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    stateNext = state;
    push      = 1'b0;
    pushData  = 8'h00;
    unique case (state)
      IDLE: if (pktAccept) stateNext = B0;
      B0: begin push = 1'b1; pushData = pktByte0; stateNext = B1; end
      B1: begin push = 1'b1; pushData = pktByte1; stateNext = B2; end
      B2: begin
        push = 1'b1; pushData = pktByte2;
`ifdef SERIAL_MOUSE_MBUTTON_EN
        stateNext = has4th ? B3 : IDLE;
      end
      B3: begin push = 1'b1; pushData = pktByte3; stateNext = IDLE; end
`else
        stateNext = IDLE;
      end
`endif
      default: stateNext = IDLE;
    endcase
    if (identHit) begin
      stateNext = IDLE;
      push      = 1'b0;
    end
  end

  // Ident flushes the queue and preloads the ident byte(s) from slot 0.
  always_ff @(posedge iClk) begin
    if (identHit) begin
      mem[0] <= 8'h4D;
`ifdef SERIAL_MOUSE_MBUTTON_EN
      mem[1] <= 8'h33;
`endif
    end else if (push) begin
      mem[wrPtr] <= pushData;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (identHit) begin
      wrPtr <= IDENT_LEN[PW-1:0];
      rdPtr <= '0;
      count <= IDENT_LEN;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      ier    <= '0;
      lcr    <= '0;
      mcr    <= '0;
      scr    <= '0;
      dll    <= 8'h0C;
      dlm    <= '0;
      oe     <= 1'b0;
      rdPrev <= 1'b0;
      intr   <= 1'b0;
    end else begin
      rdPrev <= rdAct;
      intr   <= ier[0] & dr & mcr[3];
      if (wrAct) begin
        case (off)
          3'd0: if (dlab) dll <= bus.iWrData;
          3'd1: if (dlab) dlm <= bus.iWrData; else ier <= bus.iWrData[3:0];
          3'd3: lcr <= bus.iWrData;
          3'd4: mcr <= bus.iWrData[4:0];
          3'd7: scr <= bus.iWrData;
          default: ;
        endcase
      end
      if (rdFirst && off == 3'd5) oe <= 1'b0;
      if (identHit)     oe <= 1'b0;
      else if (pktDrop) oe <= 1'b1;
    end
  end

  always_comb begin
    rdData = 8'h00;
    if (sel) begin
      case (off)
        3'd0: rdData = dlab ? dll : (dr ? mem[rdPtr] : 8'h00);
        3'd1: rdData = dlab ? dlm : {4'b0, ier};
        3'd2: rdData = (ier[0] && dr) ? 8'hC4 : 8'hC1;
        3'd3: rdData = lcr;
        3'd4: rdData = {3'b0, mcr};
        3'd5: rdData = {1'b0, 1'b1, 1'b1, 3'b0, oe, dr};
        3'd6: rdData = 8'hB0;
        default: rdData = scr;
      endcase
    end
  end

  assign bus.oRdData = rdData;
  assign bus.oSel    = sel;
  assign bus.oIntr   = intr;
endmodule

// File: tb/tb_serial_mouse_uart.sv
// Directed bench for serial_mouse_uart: a byte scoreboard filled from a reference
// conversion model, drained through RBR reads and checked with immediate assertions.
module tb_serial_mouse_uart;
  localparam logic [19:0] BASE = 20'h003F8;
  localparam int FIFO_DEPTH = 16;
`ifdef SERIAL_MOUSE_MBUTTON_EN
  localparam bit MBTN = 1'b1;
`else
  localparam bit MBTN = 1'b0;
`endif
  localparam int PKT_SLOTS = MBTN ? 4 : 3;

  logic iClk = 1'b0;
  logic iRst;
  serial_mouse_uart_if bus();

  serial_mouse_uart #(.BASE(BASE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .iClk(iClk),
    .iRst(iRst),
    .bus (bus)
  );

  always #5 iClk = ~iClk;

  int checks = 0;
  int failures = 0;
  logic [7:0] expQ[$];
  bit modelOe, modelDtrRts, modelMid;
  logic [3:0] modelIer;
  logic [4:0] modelMcr;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] msBytes(input logic [23:0] pkt);
    logic [7:0] s, dxb, dyb;
    int x, y;
    s = pkt[23:16];
    x = int'(pkt[15:8]) - (s[4] ? 256 : 0);
    y = int'(pkt[7:0]) - (s[5] ? 256 : 0);
    if (s[6]) x = s[4] ? -256 : 255;
    if (s[7]) y = s[5] ? -256 : 255;
    y = -y;
    x = (x > 127) ? 127 : ((x < -128) ? -128 : x);
    y = (y > 127) ? 127 : ((y < -128) ? -128 : y);
    dxb = x[7:0];
    dyb = y[7:0];
    return {2'b01, s[0], s[1], dyb[7:6], dxb[7:6], 2'b00, dxb[5:0], 2'b00, dyb[5:0]};
  endfunction

  task automatic modelIdent();
    expQ.delete();
    modelOe  = 1'b0;
    modelMid = 1'b0;
    expQ.push_back(8'h4D);
    if (MBTN) expQ.push_back(8'h33);
  endtask

  task automatic modelPacket(input logic [23:0] pkt);
    logic [23:0] b;
    if (!modelDtrRts) return;
    if (FIFO_DEPTH - expQ.size() < PKT_SLOTS) begin
      modelOe = 1'b1;
      return;
    end
    b = msBytes(pkt);
    expQ.push_back(b[23:16]);
    expQ.push_back(b[15:8]);
    expQ.push_back(b[7:0]);
    if (MBTN) begin
      if (pkt[18])       expQ.push_back(8'h20);
      else if (modelMid) expQ.push_back(8'h00);
      modelMid = pkt[18];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge iClk);
  endtask

  task automatic cpuWrite(input logic [2:0] off, input logic [7:0] data);
    @(negedge iClk);
    bus.iAddr = BASE + 20'(off);
    bus.iWrData = data;
    bus.iWr = 1'b1;
    @(negedge iClk);
    bus.iWr = 1'b0;
    if (off == 3'd4) begin
      if (data[0] && data[1] && !modelDtrRts) modelIdent();
      modelMcr = data[4:0];
      modelDtrRts = data[0] & data[1];
    end
    if (off == 3'd1) modelIer = data[3:0];
  endtask

  task automatic cpuRead(input logic [2:0] off, output logic [7:0] data);
    @(negedge iClk);
    bus.iAddr = BASE + 20'(off);
    bus.iRd = 1'b1;
    #1 data = bus.oRdData;
    @(negedge iClk);
    bus.iRd = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [2:0] off, input logic [7:0] exp);
    logic [7:0] d;
    cpuRead(off, d);
    check(tag, d, exp);
  endtask

  task automatic readRbr(input string tag);
    logic [7:0] exp;
    exp = (expQ.size() != 0) ? expQ.pop_front() : 8'h00;
    readCheck(tag, 3'd0, exp);
  endtask

  task automatic readLsr(input string tag);
    readCheck(tag, 3'd5, {6'b011000, modelOe, expQ.size() != 0});
    modelOe = 1'b0;
  endtask

  task automatic readIir(input string tag);
    readCheck(tag, 3'd2, (modelIer[0] && expQ.size() != 0) ? 8'hC4 : 8'hC1);
  endtask

  task automatic checkIntr(input string tag);
    idle(2);
    check(tag, {7'b0, bus.oIntr}, {7'b0, modelIer[0] & (expQ.size() != 0) & modelMcr[3]});
  endtask

  task automatic drain(input string tag);
    while (expQ.size() != 0) readRbr(tag);
    readRbr({tag, "_empty"});
  endtask

  task automatic sendPkt(input logic [23:0] pkt);
    @(negedge iClk);
    bus.iPktValid = 1'b1;
    bus.iPkt = pkt;
    @(negedge iClk);
    bus.iPktValid = 1'b0;
    modelPacket(pkt);
    idle(5);
  endtask

  task automatic modelReset();
    expQ.delete();
    modelOe = 1'b0; modelDtrRts = 1'b0; modelMid = 1'b0;
    modelIer = '0; modelMcr = '0;
  endtask

  initial begin
    logic [7:0] d;
    bus.iPktValid = 1'b0; bus.iPkt = '0; bus.iAddr = BASE;
    bus.iWr = 1'b0; bus.iWrData = '0; bus.iRd = 1'b0;
    modelReset();
    iRst = 1'b1;
    idle(3);
    iRst = 1'b0;

    // Reset state of the register file
    check("reset_intr", {7'b0, bus.oIntr}, 8'h00);
    readLsr("reset_lsr");
    readIir("reset_iir");
    readCheck("reset_ier", 3'd1, 8'h00);
    readCheck("reset_lcr", 3'd3, 8'h00);
    readCheck("reset_mcr", 3'd4, 8'h00);
    readCheck("reset_scr", 3'd7, 8'h00);
    readCheck("msr", 3'd6, 8'hB0);
    readRbr("reset_rbr_empty");
    cpuWrite(3'd3, 8'h80);
    readCheck("reset_dll", 3'd0, 8'h0C);
    readCheck("reset_dlm", 3'd1, 8'h00);
    cpuWrite(3'd0, 8'h55);
    readCheck("dll_rw", 3'd0, 8'h55);
    cpuWrite(3'd3, 8'h03);
    readCheck("lcr_rw", 3'd3, 8'h03);
    cpuWrite(3'd7, 8'hA5);
    readCheck("scr_rw", 3'd7, 8'hA5);
    @(negedge iClk);
    bus.iAddr = 20'h002F8;
    bus.iRd = 1'b1;
    #1;
    check("unsel_sel", {7'b0, bus.oSel}, 8'h00);
    check("unsel_data", bus.oRdData, 8'h00);
    @(negedge iClk);
    bus.iRd = 1'b0;

    // Ident on DTR&RTS rising
    cpuWrite(3'd4, 8'h0B);
    readCheck("mcr_rw", 3'd4, 8'h0B);
    readLsr("ident_lsr_dr");
    checkIntr("ident_intr_ier0");
    drain("ident_rbr");
    readLsr("ident_lsr_empty");

    // Conversion and interrupt
    cpuWrite(3'd1, 8'h01);
    sendPkt(24'h29_05_FD);
    checkIntr("pkt_intr_high");
    readIir("pkt_iir_c4");
    readRbr("pkt1_b0");
    readRbr("pkt1_b1");
    checkIntr("pkt_intr_still_high");
    readRbr("pkt1_b2");
    checkIntr("pkt_intr_low");
    readIir("pkt_iir_c1");
    sendPkt(24'h10_80_00);
    sendPkt(24'h40_10_00);
    sendPkt(24'hB3_7F_01);
    drain("conv");

    // Fill the FIFO, then overflow
    cpuWrite(3'd4, 8'h00);
    cpuWrite(3'd4, 8'h0B);
    for (int i = 0; i < 6; i++) sendPkt({8'h08 | 8'(i), 8'(i * 7), 8'(8'hF0 + 8'(i))});
    readLsr("fill_lsr_oe");
    readLsr("fill_lsr_oe_cleared");
    drain("fill");

    // Back-to-back strobes, then packets while DTR/RTS low
    @(negedge iClk);
    bus.iPktValid = 1'b1; bus.iPkt = 24'h0A_03_02;
    @(negedge iClk);
    bus.iPkt = 24'h09_11_22;
    @(negedge iClk);
    bus.iPktValid = 1'b0;
    modelPacket(24'h0A_03_02);
    if (modelDtrRts) modelOe = 1'b1;
    idle(5);
    readLsr("b2b_lsr");
    drain("b2b");
    cpuWrite(3'd4, 8'h08);
    sendPkt(24'h09_05_05);
    readLsr("dtr_low_lsr");
    readRbr("dtr_low_rbr");

    // Reset in the middle of a packet
    cpuWrite(3'd4, 8'h0B);
    drain("pre_rst");
    @(negedge iClk);
    bus.iPktValid = 1'b1; bus.iPkt = 24'h09_40_40;
    @(negedge iClk);
    bus.iPktValid = 1'b0;
    @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    modelReset();
    check("rst_mid_intr", {7'b0, bus.oIntr}, 8'h00);
    readLsr("rst_mid_lsr");
    idle(4);
    readRbr("rst_mid_rbr");

    // Middle-button sequence (plain 3-byte packets without the extension)
    cpuWrite(3'd4, 8'h0B);
    drain("mb_ident");
    sendPkt(24'h0C_00_00);
    sendPkt(24'h08_00_00);
    sendPkt(24'h08_00_00);
    sendPkt(24'h0C_01_00);
    cpuWrite(3'd4, 8'h00);
    cpuWrite(3'd4, 8'h0B);
    sendPkt(24'h08_00_00);
    drain("mb");
    readLsr("final_lsr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
